// File: rtl/class_arbiter.sv
// class_arbiter: four-class round-robin burst arbiter; define ARB_STRICT_PRIO_EN to make class 0 win every arbitration
module class_arbiter #(
    parameter int DATA_WIDTH = 12,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  empty_0,
    input  logic                  empty_1,
    input  logic                  empty_2,
    input  logic                  empty_3,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [DATA_WIDTH-1:0] data_in3,
    input  logic                  pause,
    output logic                  pop_0,
    output logic                  pop_1,
    output logic                  pop_2,
    output logic                  pop_3,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [1:0]            grant,
    output logic                  busy
);
    typedef enum logic {IDLE, SERVE} state_t;
    state_t state, state_n;
    logic [1:0] last_grant, last_n, grant_n, start, off, sel;
    logic [3:0] cnt, cnt_n, ne, rot;
    logic cur_empty, pop, done;
    logic [DATA_WIDTH-1:0] head;
    assign ne = ~{empty_3, empty_2, empty_1, empty_0};
    assign start = last_grant + 2'd1;
    assign rot = 4'({ne, ne} >> start);
    assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
`ifdef ARB_STRICT_PRIO_EN
    assign sel = ne[0] ? 2'd0 : start + off;
`else
    assign sel = start + off;
`endif
    assign cur_empty = ~ne[grant];
    assign head = grant == 2'd0 ? data_in0 : grant == 2'd1 ? data_in1 : grant == 2'd2 ? data_in2 : data_in3;
    assign pop = state == SERVE && !cur_empty && !pause && !reset;
    assign pop_0 = pop && grant == 2'd0;
    assign pop_1 = pop && grant == 2'd1;
    assign pop_2 = pop && grant == 2'd2;
    assign pop_3 = pop && grant == 2'd3;
    assign busy = state == SERVE;
    assign done = (cnt + 4'd1) == 4'(BURST_LEN);
    // next state: arbitrate in IDLE, count pops and release the class in SERVE
    always_comb begin
        state_n = state;
        grant_n = grant;
        last_n = last_grant;
        cnt_n = cnt;
        if (state == IDLE) begin
            if (|ne) begin
                state_n = SERVE;
                grant_n = sel;
                cnt_n = 4'd0;
            end
        end else if (!pause) begin
            if (cur_empty || done) begin
                state_n = IDLE;
                last_n = grant;
            end
            if (!cur_empty) cnt_n = cnt + 4'd1;
        end
    end
    // state registers and the registered merged output
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last_grant <= 2'd3;
            grant <= 2'd0;
            cnt <= 4'd0;
            data_out <= '0;
            valid_out <= 1'b0;
        end else begin
            state <= state_n;
            last_grant <= last_n;
            grant <= grant_n;
            cnt <= cnt_n;
            valid_out <= pop;
            if (pop) data_out <= head;
        end
    end
endmodule
